// File: rtl/seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_pkg
// Shared definitions for the 7-segment scan driver: the "everything off" pin
// codes, the scan FSM state encoding and the digit-index width used by the
// external digit-select counter.
// -----------------------------------------------------------------------------
package seg_scan_driver_pkg;

   localparam int DIG_W = 3;                  // digit index width (8 digits max)

   localparam logic [6:0] SEG_BLANK = 7'h7F;  // all cathodes off (active-low)
   localparam logic [7:0] AN_OFF    = 8'hFF;  // all anodes off (active-low)

   typedef logic [DIG_W-1:0] dig_idx_t;       // digit index 0..7
   typedef logic [DIG_W:0]   dig_cnt_t;       // digit count 0..8

   typedef enum logic [1:0] {
      BLANK,    // all anodes off while the digit select settles
      SHOW,     // selected digit lit
      ADVANCE,  // one rotate strobe to step the digit select
      SKIP      // extra rotate strobes to jump over unused indices
   } state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Bundles everything around the scan driver except clk/rst:
//   en, switch, load, digits_in, dp_in : into the driver
//   rotate                             : strobe out to the digit-select counter
//   an, seg, dp                        : board pins, active-low
// Modports: slave = the scan driver, master = whatever surrounds it.
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
   import seg_scan_driver_pkg::*;

   logic        en;
   dig_idx_t    switch;
   logic        load;
   logic [31:0] digits_in;
   logic [7:0]  dp_in;
   logic        rotate;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport slave (
      input  en, switch, load, digits_in, dp_in,
      output rotate, an, seg, dp
   );

   modport master (
      output en, switch, load, digits_in, dp_in,
      input  rotate, an, seg, dp
   );

endinterface

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Hex nibble to 7-segment code, active-low, bit order {g,f,e,d,c,b,a}.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  cathode pattern (0 = segment lit)
// -----------------------------------------------------------------------------
module seg_hex_decode
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      // NOTE: the default assignment up front keeps every path driven, so
      // no latch can be inferred even if the case below is edited later.
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Multiplexed 8-digit 7-segment driver. Lights the digit chosen by an external
// digit-select counter, blanks between digits to avoid ghosting, and pulses
// rotate to step that counter. Digits are double-buffered: load fills a
// shadow copy which becomes visible only at the frame boundary.
// Ports:
//   clk  in  1   system clock
//   rst  in  1   synchronous, active-high reset
//   bus  slave   seg_scan_driver_if (en/switch/load/digits_in/dp_in in,
//                rotate/an/seg/dp out; pins active-low)
// Parameters:
//   DWELL_CYCLES  cycles a digit is lit per visit (>= 1)
//   BLANK_CYCLES  cycles dark before each digit (>= 1)
//   NUM_DIGITS    digits scanned (1..8); higher indices are skipped
//   CNT_W         timer width, must hold max(DWELL_CYCLES, BLANK_CYCLES)
// -----------------------------------------------------------------------------
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int DWELL_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int NUM_DIGITS   = 8,
   parameter int CNT_W        = 17
) (
   input  logic             clk,
   input  logic             rst,
   seg_scan_driver_if.slave bus
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam dig_idx_t         LAST_IDX   = dig_idx_t'(NUM_DIGITS - 1);
   localparam dig_cnt_t         NUM_DIG    = dig_cnt_t'(NUM_DIGITS);
   localparam bit               HAS_SKIP   = (NUM_DIGITS < 8);
   // Last SKIP cycle index: SKIP lasts 8-NUM_DIGITS cycles (unused when 8 digits).
   localparam dig_idx_t         SKIP_LAST  = dig_idx_t'(7 - NUM_DIGITS);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer;
   dig_idx_t         skip_cnt;

   logic [31:0] shadow_dig, active_dig;
   logic [7:0]  shadow_dp,  active_dp;

   logic       in_range, frame_end;
   logic [3:0] cur_nib;
   logic [6:0] dec_seg;

   logic [7:0] an_nxt,  an_q;
   logic [6:0] seg_nxt, seg_q;
   logic       dp_nxt,  dp_q;
   logic       rotate_q;

   // A desynced counter (index >= NUM_DIGITS) is shown dark but still rotated,
   // so the scan realigns itself within one lap.
   assign in_range  = ({1'b0, bus.switch} < NUM_DIG);
   assign frame_end = (bus.switch == LAST_IDX);
   assign cur_nib   = active_dig[{bus.switch, 2'b00} +: 4];

   seg_hex_decode u_dec (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_nxt = state;
      case (state)
         BLANK:   if (timer == BLANK_LAST) state_nxt = SHOW;
         SHOW:    if (timer == DWELL_LAST) state_nxt = ADVANCE;
         ADVANCE: state_nxt = (frame_end && HAS_SKIP) ? SKIP : BLANK;
         SKIP:    if (skip_cnt == SKIP_LAST) state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase
      // Disabled: park in BLANK so re-enabling always starts with a full gap.
      if (!bus.en) state_nxt = BLANK;
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      if (rst) begin
         state    <= BLANK;
         timer    <= '0;
         skip_cnt <= '0;
      end else begin
         state    <= state_nxt;
         timer    <= (state_nxt != state || !bus.en) ? '0 : timer + CNT_W'(1);
         skip_cnt <= (state == SKIP && state_nxt == SKIP) ?
                     skip_cnt + dig_idx_t'(1) : '0;
      end
   end

   // ------------------------------------------------------ double buffer
   always_ff @(posedge clk) begin
      // NOTE: the digit buffers are reset (not left uninitialised) so the
      // first frame after reset shows a defined all-zero display.
      if (rst) begin
         shadow_dig <= '0;
         shadow_dp  <= '0;
         active_dig <= '0;
         active_dp  <= '0;
      end else begin
         if (bus.load) begin
            shadow_dig <= bus.digits_in;
            shadow_dp  <= bus.dp_in;
         end
         // Frame boundary: a load landing in this exact cycle bypasses the
         // shadow so it is not held back a whole frame.
         if (state == ADVANCE && frame_end) begin
            active_dig <= bus.load ? bus.digits_in : shadow_dig;
            active_dp  <= bus.load ? bus.dp_in     : shadow_dp;
         end
      end
   end

   // ------------------------------------------------------------ outputs
   always_comb begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
      if (bus.en && state == SHOW && in_range) begin
         an_nxt[bus.switch] = 1'b0;
         seg_nxt            = dec_seg;
         dp_nxt             = ~active_dp[bus.switch];
      end
   end

   // Pins follow the current state one cycle later; rotate is taken from the
   // next state so it is high exactly during ADVANCE/SKIP.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_q     <= AN_OFF;
         seg_q    <= SEG_BLANK;
         dp_q     <= 1'b1;
         rotate_q <= 1'b0;
      end else begin
         an_q     <= an_nxt;
         seg_q    <= seg_nxt;
         dp_q     <= dp_nxt;
         rotate_q <= (state_nxt == ADVANCE) || (state_nxt == SKIP);
      end
   end

   assign bus.an     = an_q;
   assign bus.seg    = seg_q;
   assign bus.dp     = dp_q;
   assign bus.rotate = rotate_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Two drivers (8 and 6 digits, DWELL=4, BLANK=2), each paired with its own
// digit-select counter sharing rst. Inputs are driven and outputs sampled on
// the falling edge. Per-digit timing with the driver in steady state:
// lit on samples +0..+3, rotate on +3, dark on +4..+6, next digit at +7.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;
   import seg_scan_driver_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en, load, set6;
   logic [31:0] digits_in;
   logic [7:0]  dp_in;
   dig_idx_t    set6_val;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int an6_bad  = 0;
   int rot8_cnt = 0;

   logic [6:0] hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   seg_scan_driver_if if8 ();
   seg_scan_driver_if if6 ();

   assign if8.en = en;        assign if6.en = en;
   assign if8.load = load;    assign if6.load = load;
   assign if8.digits_in = digits_in;  assign if6.digits_in = digits_in;
   assign if8.dp_in = dp_in;  assign if6.dp_in = dp_in;

   seg_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_DIGITS(8), .CNT_W(4))
      dut8 (.clk(clk), .rst(rst), .bus(if8));

   seg_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_DIGITS(6), .CNT_W(4))
      dut6 (.clk(clk), .rst(rst), .bus(if6));

   // Digit-select counters; the 6-digit one can be preset to force a desync.
   always_ff @(posedge clk) begin
      if (rst)              if8.switch <= '0;
      else if (if8.rotate)  if8.switch <= if8.switch + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)              if6.switch <= '0;
      else if (set6)        if6.switch <= set6_val;
      else if (if6.rotate)  if6.switch <= if6.switch + 3'd1;
   end

   always @(negedge clk) if (!rst && if6.an[7:6] != 2'b11) an6_bad++;
   always @(posedge clk) if (!rst && if8.rotate) rot8_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks one digit visit of the 8-digit driver starting at its first lit
   // sample; optionally drives a load during the ADVANCE cycle.
   task automatic expect_digit8(input string tag, input int d, input logic [31:0] data,
                                input logic [7:0] dps, input bit load_at_adv,
                                input logic [31:0] new_data, input logic [7:0] new_dp);
      logic [3:0] nib;
      logic [7:0] an_exp;
      logic       dp_exp;
      string      t;
      nib    = data[4*d +: 4];
      an_exp = 8'hFF;
      an_exp[d] = 1'b0;
      dp_exp = ~dps[d];
      t = $sformatf("%s_d%0d", tag, d);
      check({t, "_an"},  32'(if8.an), 32'(an_exp));
      check({t, "_seg"}, 32'(if8.seg), 32'(hex_seg[nib]));
      check({t, "_dp"},  32'(if8.dp), 32'(dp_exp));
      check({t, "_sw"},  32'(if8.switch), 32'(d));
      check({t, "_rot0"}, 32'(if8.rotate), 32'd0);
      repeat (3) begin
         @(negedge clk);
         load = 1'b0;
      end
      check({t, "_rot1"}, 32'(if8.rotate), 32'd1);
      check({t, "_an_adv"}, 32'(if8.an), 32'(an_exp));
      if (load_at_adv) begin
         load = 1'b1; digits_in = new_data; dp_in = new_dp;
      end
      @(negedge clk);
      load = 1'b0;
      check({t, "_blank_an"}, 32'(if8.an), 32'hFF);
      check({t, "_blank_rot"}, 32'(if8.rotate), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic expect_frame8(input string tag, input logic [31:0] data, input logic [7:0] dps);
      for (int d = 0; d < 8; d++) expect_digit8(tag, d, data, dps, 1'b0, 32'h0, 8'h0);
   endtask

   // Bounded search for a rotate strobe of the 6-digit driver at a given index.
   task automatic wait6(input dig_idx_t sw, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (if6.rotate === 1'b1 && if6.switch === sw) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int rot_before;
      en = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; set6 = 1'b0; set6_val = '0;

      // Reset held for 3 cycles.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an",  32'(if8.an), 32'hFF);
      check("rst_seg", 32'(if8.seg), 32'h7F);
      check("rst_dp",  32'(if8.dp), 32'd1);
      check("rst_rot", 32'(if8.rotate), 32'd0);
      check("rst_sw",  32'(if8.switch), 32'd0);
      check("rst_an6", 32'(if6.an), 32'hFF);

      // Release reset and queue the first frame data.
      rst = 1'b0; load = 1'b1; digits_in = 32'h76543210; dp_in = 8'h01;
      @(negedge clk);
      load = 1'b0;
      check("start_blank0", 32'(if8.an), 32'hFF);
      @(negedge clk);
      check("start_blank1", 32'(if8.an), 32'hFF);
      @(negedge clk);

      // Frame 0 still shows reset data; frame 1 shows the load.
      expect_frame8("f0", 32'h0, 8'h00);
      expect_frame8("f1", 32'h76543210, 8'h01);

      // Mid-frame load at digit 2 must not disturb the current frame.
      expect_digit8("f2", 0, 32'h76543210, 8'h01, 1'b0, 32'h0, 8'h0);
      expect_digit8("f2", 1, 32'h76543210, 8'h01, 1'b0, 32'h0, 8'h0);
      load = 1'b1; digits_in = 32'hFFFFFFFF; dp_in = 8'h00;
      for (int d = 2; d < 8; d++) expect_digit8("f2", d, 32'h76543210, 8'h01, 1'b0, 32'h0, 8'h0);

      // Frame 3 shows all F; load coincident with its boundary ADVANCE.
      for (int d = 0; d < 7; d++) expect_digit8("f3", d, 32'hFFFFFFFF, 8'h00, 1'b0, 32'h0, 8'h0);
      expect_digit8("f3", 7, 32'hFFFFFFFF, 8'h00, 1'b1, 32'hFEDCBA98, 8'h80);
      for (int d = 0; d < 3; d++) expect_digit8("f4", d, 32'hFEDCBA98, 8'h80, 1'b0, 32'h0, 8'h0);

      // Enable dropped during SHOW of digit 3.
      check("en_pre_an", 32'(if8.an), 32'hF7);
      en = 1'b0;
      rot_before = rot8_cnt;
      @(negedge clk);
      check("en_off_an",  32'(if8.an), 32'hFF);
      check("en_off_rot", 32'(if8.rotate), 32'd0);
      check("en_off_sw",  32'(if8.switch), 32'd3);
      repeat (8) @(negedge clk);
      check("en_hold_sw",   32'(if8.switch), 32'd3);
      check("en_hold_rots", 32'(rot8_cnt), 32'(rot_before));
      check("en_hold_an",   32'(if8.an), 32'hFF);
      en = 1'b1;
      @(negedge clk);
      check("en_on_blank0", 32'(if8.an), 32'hFF);
      @(negedge clk);
      check("en_on_blank1", 32'(if8.an), 32'hFF);
      @(negedge clk);
      check("en_on_an",  32'(if8.an), 32'hF7);
      check("en_on_seg", 32'(if8.seg), 32'h03);
      check("en_on_dp",  32'(if8.dp), 32'd1);

      // Skip of unused indices on the 6-digit driver.
      wait6(3'd5, ok);
      check("skip_found", 32'(ok), 32'd1);
      check("skip_a_sw", 32'(if6.switch), 32'd5);
      @(negedge clk);
      check("skip_b_rot", 32'(if6.rotate), 32'd1);
      check("skip_b_sw",  32'(if6.switch), 32'd6);
      @(negedge clk);
      check("skip_c_rot", 32'(if6.rotate), 32'd1);
      check("skip_c_sw",  32'(if6.switch), 32'd7);
      @(negedge clk);
      check("skip_d_rot", 32'(if6.rotate), 32'd0);
      check("skip_d_sw",  32'(if6.switch), 32'd0);
      repeat (3) @(negedge clk);
      check("skip_next_an", 32'(if6.an), 32'hFE);

      // Reset during SKIP.
      wait6(3'd6, ok);
      check("skip2_found", 32'(ok), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_rot", 32'(if6.rotate), 32'd0);
      check("mrst_sw",  32'(if6.switch), 32'd0);
      check("mrst_an",  32'(if6.an), 32'hFF);
      @(negedge clk);

      // Desync: counter forced to 7 on a 6-digit display.
      rst = 1'b0; set6 = 1'b1; set6_val = 3'd7;
      @(negedge clk);
      set6 = 1'b0;
      check("dsync_sw7", 32'(if6.switch), 32'd7);
      repeat (3) @(negedge clk);
      check("dsync_dark", 32'(if6.an), 32'hFF);
      repeat (2) @(negedge clk);
      check("dsync_rot", 32'(if6.rotate), 32'd1);
      check("dsync_sw",  32'(if6.switch), 32'd7);
      @(negedge clk);
      check("dsync_wrap_rot", 32'(if6.rotate), 32'd0);
      check("dsync_wrap_sw",  32'(if6.switch), 32'd0);
      repeat (3) @(negedge clk);
      check("dsync_d0_an",  32'(if6.an), 32'hFE);
      check("dsync_d0_seg", 32'(if6.seg), 32'h40);
      check("dsync_d0_dp",  32'(if6.dp), 32'd1);

      check("an6_unused_dark", 32'(an6_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
